// File: rtl/mixer_pkg.sv
// Shared types and helpers for the time-multiplexed stereo mixer.
package mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LATCH = 2'd2
  } mix_state_e;

  // Sized so that NCH full-scale products can never wrap.
  function automatic int acc_width(input int nch, input int ch_w, input int gain_w);
    return ch_w + gain_w + $clog2(nch) + 1;
  endfunction

  // Clamp an unsigned value to the largest w-bit code.
  function automatic logic [63:0] saturate(input logic [63:0] v, input int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/sd_dac1.sv
// First-order sigma-delta modulator: the carry out of a W-bit phase accumulator is the 1-bit output.
module sd_dac1 #(
  parameter int W = 14
) (
  input  logic         clk28,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic         out
);

  logic [W:0] cnt_q;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= {1'b0, cnt_q[W-1:0]} + {1'b0, level};
    end
  end

  assign out = cnt_q[W];

endmodule

// File: rtl/mixer_tdm.sv
// NCH-source stereo mixer using one shared multiply-accumulate per side, stepped channel by channel,
// followed by two sigma-delta 1-bit DACs.
module mixer_tdm
  import mixer_pkg::*;
#(
  parameter int NCH    = 11,
  parameter int CH_W   = 8,
  parameter int GAIN_W = 4,
  parameter int DAC_W  = 14,
  parameter int SHIFT  = 2
) (
  input  logic                   clk28,
  input  logic                   rst,
  input  logic                   sample_stb,
  input  logic [NCH*CH_W-1:0]    ch_sample,
  input  logic [NCH*GAIN_W-1:0]  gain_l,
  input  logic [NCH*GAIN_W-1:0]  gain_r,
  input  logic [NCH-1:0]         mute,
  input  logic                   mono,
  output logic                   busy,
  output logic                   overrun,
  output logic [DAC_W-1:0]       level_l,
  output logic [DAC_W-1:0]       level_r,
  output logic                   dac_l,
  output logic                   dac_r
);

  localparam int ACC_W = acc_width(NCH, CH_W, GAIN_W);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PRD_W = CH_W + GAIN_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

  mix_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic                    overrun_q;
  logic                    start;

  logic [NCH*CH_W-1:0]     snap_s_q;
  logic [NCH*GAIN_W-1:0]   snap_gl_q, snap_gr_q;
  logic [NCH-1:0]          snap_m_q;

  logic [CH_W-1:0]         s_sel;
  logic [GAIN_W-1:0]       gl_sel, gr_sel;
  logic                    m_sel;

  logic [PRD_W-1:0]        prod_l_p0, prod_r_p0;
  logic                    vld_p0;
  logic [ACC_W-1:0]        acc_l_q, acc_r_q;
  logic                    vld_p1, mono_p1;

  logic [ACC_W:0]          sum_lr, mix_l, mix_r;
  logic [DAC_W-1:0]        level_l_q, level_r_q, level_l_d, level_r_d;

  assign start = (state_q == ST_IDLE) && sample_stb;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sample_stb) state_d = ST_ACCUM;
      ST_ACCUM: if (idx_q == IDX_LAST) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      mono_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= sample_stb && (state_q != ST_IDLE);
      vld_p0    <= (state_q == ST_ACCUM);
      vld_p1    <= (state_q == ST_LATCH);
      if (state_q == ST_LATCH) mono_p1 <= mono;
      if (start) begin
        idx_q <= '0;
      end else if (state_q == ST_ACCUM) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Snapshot: the pass only ever sees the inputs present at the strobe.
  always_ff @(posedge clk28) begin
    if (start) begin
      snap_s_q  <= ch_sample;
      snap_gl_q <= gain_l;
      snap_gr_q <= gain_r;
      snap_m_q  <= mute;
    end
  end

  assign s_sel  = snap_s_q[idx_q*CH_W +: CH_W];
  assign gl_sel = snap_gl_q[idx_q*GAIN_W +: GAIN_W];
  assign gr_sel = snap_gr_q[idx_q*GAIN_W +: GAIN_W];
  assign m_sel  = snap_m_q[idx_q];

  // Stage p0: per-channel product; the last one is summed while in LATCH.
  always_ff @(posedge clk28) begin
    prod_l_p0 <= m_sel ? '0 : PRD_W'(s_sel) * PRD_W'(gl_sel);
    prod_r_p0 <= m_sel ? '0 : PRD_W'(s_sel) * PRD_W'(gr_sel);
  end

  always_comb begin
    sum_lr = {1'b0, acc_l_q} + {1'b0, acc_r_q};
    if (mono_p1) begin
      mix_l = sum_lr >> (SHIFT + 1);
      mix_r = mix_l;
    end else begin
      mix_l = {1'b0, acc_l_q} >> SHIFT;
      mix_r = {1'b0, acc_r_q} >> SHIFT;
    end
  end

  assign level_l_d = DAC_W'(saturate(64'(mix_l), DAC_W));
  assign level_r_d = DAC_W'(saturate(64'(mix_r), DAC_W));

  // Stage p1: completed sums are scaled, saturated and published.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      level_l_q <= '0;
      level_r_q <= '0;
    end else begin
      if (start) begin
        acc_l_q <= '0;
        acc_r_q <= '0;
      end else if (vld_p0) begin
        acc_l_q <= acc_l_q + ACC_W'(prod_l_p0);
        acc_r_q <= acc_r_q + ACC_W'(prod_r_p0);
      end
      if (vld_p1) begin
        level_l_q <= level_l_d;
        level_r_q <= level_r_d;
      end
    end
  end

  sd_dac1 #(.W(DAC_W)) u_dac_l (
    .clk28 (clk28),
    .rst   (rst),
    .level (level_l_q),
    .out   (dac_l)
  );

  sd_dac1 #(.W(DAC_W)) u_dac_r (
    .clk28 (clk28),
    .rst   (rst),
    .level (level_r_q),
    .out   (dac_r)
  );

  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;
  assign level_l = level_l_q;
  assign level_r = level_r_q;

endmodule

// File: tb/tb_mixer_tdm.sv
// Bench for mixer_tdm: default 11-channel instance plus a small 4-channel saturating instance.
module tb_mixer_tdm;

  localparam int NCH = 11, CH_W = 8, GAIN_W = 4, DAC_W = 14, SHIFT = 2;
  localparam int NB = 4, DB = 12;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;

  logic                  sample_stb = 1'b0;
  logic [NCH*CH_W-1:0]   ch_sample  = '0;
  logic [NCH*GAIN_W-1:0] gain_l     = '0;
  logic [NCH*GAIN_W-1:0] gain_r     = '0;
  logic [NCH-1:0]        mute       = '1;
  logic                  mono       = 1'b0;
  logic                  busy, overrun, dac_l, dac_r;
  logic [DAC_W-1:0]      level_l, level_r;

  logic                  stb_b  = 1'b0;
  logic [NB*CH_W-1:0]    ch_b   = '0;
  logic [NB*GAIN_W-1:0]  gl_b   = '0;
  logic [NB*GAIN_W-1:0]  gr_b   = '0;
  logic [NB-1:0]         mute_b = '0;
  logic                  mono_b = 1'b0;
  logic                  busy_b, ovr_b, dac_l_b, dac_r_b;
  logic [DB-1:0]         lvl_l_b, lvl_r_b;

  int total = 0;
  int bad   = 0;

  always #5 clk28 = ~clk28;

  mixer_tdm dut (
    .clk28(clk28), .rst(rst), .sample_stb(sample_stb), .ch_sample(ch_sample),
    .gain_l(gain_l), .gain_r(gain_r), .mute(mute), .mono(mono),
    .busy(busy), .overrun(overrun), .level_l(level_l), .level_r(level_r),
    .dac_l(dac_l), .dac_r(dac_r)
  );

  mixer_tdm #(.NCH(NB), .CH_W(CH_W), .GAIN_W(GAIN_W), .DAC_W(DB), .SHIFT(0)) dut_b (
    .clk28(clk28), .rst(rst), .sample_stb(stb_b), .ch_sample(ch_b),
    .gain_l(gl_b), .gain_r(gr_b), .mute(mute_b), .mono(mono_b),
    .busy(busy_b), .overrun(ovr_b), .level_l(lvl_l_b), .level_r(lvl_r_b),
    .dac_l(dac_l_b), .dac_r(dac_r_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  // Reference: weighted sum of unmuted channels, scaled, optionally folded to mono, clamped.
  function automatic void mix_model(input int n, input int shift, input int dacw,
                                    input logic [255:0] s, input logic [127:0] gl,
                                    input logic [127:0] gr, input logic [31:0] m,
                                    input logic mo, output int l, output int r);
    int sl, sr, mx;
    sl = 0;
    sr = 0;
    for (int i = 0; i < n; i++) begin
      if (!m[i]) begin
        sl += int'(s[i*8 +: 8]) * int'(gl[i*4 +: 4]);
        sr += int'(s[i*8 +: 8]) * int'(gr[i*4 +: 4]);
      end
    end
    if (mo) begin
      l = (sl + sr) >> (shift + 1);
      r = l;
    end else begin
      l = sl >> shift;
      r = sr >> shift;
    end
    mx = (1 << dacw) - 1;
    if (l > mx) l = mx;
    if (r > mx) r = mx;
  endfunction

  function automatic void model_a(output int l, output int r);
    mix_model(NCH, SHIFT, DAC_W, 256'(ch_sample), 128'(gain_l), 128'(gain_r),
              32'(mute), mono, l, r);
  endfunction

  task automatic set_ch(input int i, input int s, input int gl, input int gr, input bit m);
    ch_sample[i*CH_W +: CH_W]  = CH_W'(s);
    gain_l[i*GAIN_W +: GAIN_W] = GAIN_W'(gl);
    gain_r[i*GAIN_W +: GAIN_W] = GAIN_W'(gr);
    mute[i]                    = m;
  endtask

  // One strobe; checks the level holds until edge 13, updates there, and busy lasts 12 cycles.
  task automatic strobe_and_check(input string tag, input int el, input int er);
    int nb;
    logic [DAC_W-1:0] old_l;
    old_l = level_l;
    nb = 0;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    nb += int'(busy);
    for (int k = 1; k <= 12; k++) begin
      tick();
      nb += int'(busy);
    end
    check({tag, "_hold"}, 32'(level_l), 32'(old_l));
    tick();
    check({tag, "_l"}, 32'(level_l), 32'(el));
    check({tag, "_r"}, 32'(level_r), 32'(er));
    for (int k = 0; k < 4; k++) begin
      tick();
      nb += int'(busy);
    end
    check({tag, "_busy_cycles"}, 32'(nb), 32'd12);
  endtask

  initial begin
    int el, er, el2, er2, ones, ones_r, alt_err, nz;
    logic prev;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_level_l", 32'(level_l), 32'd0);
    check("rst_level_r", 32'(level_r), 32'd0);
    check("rst_dac_l", 32'(dac_l), 32'd0);
    rst = 1'b0;
    tick();

    // Gains and latency
    set_ch(0, 200, 15, 0, 1'b0);
    set_ch(1, 100, 0, 15, 1'b0);
    strobe_and_check("gain", 750, 375);

    // Mono fold
    mono = 1'b1;
    strobe_and_check("mono", 562, 562);
    mono = 1'b0;

    // Overrun, snapshot isolation and back-to-back restart
    set_ch(2, 50, 3, 7, 1'b0);
    model_a(el, er);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    for (int i = 0; i < NCH; i++)
      set_ch(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    for (int k = 1; k <= 4; k++) tick();
    check("ovr_before", 32'(overrun), 32'd0);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    tick();
    check("ovr_one_cycle", 32'(overrun), 32'd0);
    for (int k = 7; k <= 12; k++) tick();
    check("ovr_idle", 32'(busy), 32'd0);
    model_a(el2, er2);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    check("ovr_first_l", 32'(level_l), 32'(el));
    check("ovr_first_r", 32'(level_r), 32'(er));
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_no_ovr", 32'(overrun), 32'd0);
    for (int k = 1; k <= 13; k++) tick();
    check("restart_l", 32'(level_l), 32'(el2));
    check("restart_r", 32'(level_r), 32'(er2));
    tick();

    // Randomized passes
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NCH; i++)
        set_ch(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      mono = 1'($urandom_range(0, 1));
      model_a(el, er);
      strobe_and_check($sformatf("rand%0d", p), el, er);
    end
    mono = 1'b0;

    // Sigma-delta duty at half scale on the left, zero on the right
    for (int i = 0; i < 8; i++) set_ch(i, 255, 15, 0, 1'b0);
    set_ch(8, 255, 8, 0, 1'b0);
    set_ch(9, 128, 1, 0, 1'b0);
    set_ch(10, 0, 0, 0, 1'b1);
    model_a(el, er);
    strobe_and_check("sd_set", el, er);
    check("sd_level", 32'(level_l), 32'd8192);
    tick();
    ones = 0;
    ones_r = 0;
    alt_err = 0;
    prev = dac_l;
    for (int k = 0; k < 16384; k++) begin
      tick();
      ones += int'(dac_l);
      ones_r += int'(dac_r);
      if (dac_l == prev) alt_err++;
      prev = dac_l;
    end
    check("sd_half_ones", 32'(ones), 32'd8192);
    check("sd_alternate", 32'(alt_err), 32'd0);
    check("sd_zero_ones", 32'(ones_r), 32'd0);

    // Saturation on the 4-channel, unshifted instance
    for (int i = 0; i < NB; i++) begin
      ch_b[i*CH_W +: CH_W]  = 8'd255;
      gl_b[i*GAIN_W +: GAIN_W] = 4'd15;
      gr_b[i*GAIN_W +: GAIN_W] = 4'd15;
    end
    mix_model(NB, 0, DB, 256'(ch_b), 128'(gl_b), 128'(gr_b), 32'(mute_b), mono_b, el, er);
    stb_b = 1'b1;
    tick();
    stb_b = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    check("sat_l", 32'(lvl_l_b), 32'(el));
    check("sat_r", 32'(lvl_r_b), 32'd4095);
    check("sat_busy", 32'(busy_b), 32'd0);
    check("sat_ovr", 32'(ovr_b), 32'd0);
    tick();
    ones = 0;
    ones_r = 0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      ones += int'(dac_l_b);
      ones_r += int'(dac_r_b);
    end
    check("sd_max_l", 32'(ones), 32'd4095);
    check("sd_max_r", 32'(ones_r), 32'd4095);

    // Reset in the middle of a pass
    for (int i = 0; i < NCH; i++) set_ch(i, 200, 9, 11, 1'b0);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_level", 32'(level_l), 32'd0);
    tick();
    rst = 1'b0;
    nz = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (busy || level_l != 0 || level_r != 0 || dac_l || dac_r) nz++;
    end
    check("rst_quiet", 32'(nz), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
